// File: rtl/instruction_rom_bank.sv
// Instruction store: DEFAULT_WORD fill for DEPTH cycles after reset, then 1-cycle registered reads with a
// one-entry output register (ReadReady = !ReadValid || ReadAck); program port writable until the sticky lock sets.
module instruction_rom_bank #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    DEPTH        = 1024,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ReadReq,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic                  ReadReady,
  output logic                  ReadValid,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  ReadAck,
  input  logic                  ProgWrite,
  input  logic [ADDR_WIDTH-1:0] ProgAddr,
  input  logic [DATA_WIDTH-1:0] ProgData,
  input  logic                  ProgLock,
  output logic                  Locked,
  output logic                  InitDone,
  output logic                  ProgError
);

  localparam int                    IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LAST_V  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_V   = (ADDR_WIDTH+1)'(1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic                  rd_acc, rd_in_range, wr_in_range, wr_ok;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdat;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rd_in_range = {1'b0, ReadAddr} < DEPTH_V;
  assign wr_in_range = {1'b0, ProgAddr} < DEPTH_V;
  assign rd_acc      = ReadReq && ReadReady;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    mem_we    = 1'b0;
    mem_waddr = ProgAddr[IDX_W-1:0];
    mem_wdat  = ProgData;
    ReadReady = 1'b0;
    InitDone  = 1'b0;
    wr_ok     = 1'b0;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = fill_q[IDX_W-1:0];
        mem_wdat  = DEFAULT_WORD;
        fill_d    = fill_q + ONE_V;
        if (fill_q == LAST_V) state_d = RUN;
      end
      RUN: begin
        ReadReady = !ReadValid || ReadAck;
        InitDone  = 1'b1;
        // Lock is sampled before its own update, so a write alongside ProgLock still lands.
        wr_ok     = ProgWrite && !Locked && wr_in_range;
        mem_we    = wr_ok;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

  // Output register reads the array with the pre-write contents (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadValid <= 1'b0;
      ReadData  <= '0;
    end else if (rd_acc) begin
      ReadValid <= 1'b1;
      ReadData  <= rd_in_range ? mem[ReadAddr[IDX_W-1:0]] : DEFAULT_WORD;
    end else if (ReadAck) begin
      ReadValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Locked    <= 1'b0;
      ProgError <= 1'b0;
    end else begin
      Locked    <= Locked || ProgLock;
      ProgError <= ProgWrite && !wr_ok;
    end
  end

endmodule

// File: tb/tb_instruction_rom_bank.sv
// Bench for instruction_rom_bank: a DEPTH=1024 instance for the main flow and a DEPTH=24 instance for range limits.
module tb_instruction_rom_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rreq, rrdy, rvld, rack, pw, plock, locked, idone, perr;
  logic [9:0]  raddr, paddr;
  logic [15:0] rdat, pdat;

  logic        s_rreq, s_rrdy, s_rvld, s_rack, s_pw, s_plock, s_locked, s_idone, s_perr;
  logic [9:0]  s_raddr, s_paddr;
  logic [15:0] s_rdat, s_pdat;

  instruction_rom_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(1024), .DEFAULT_WORD(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .ReadReq(rreq), .ReadAddr(raddr), .ReadReady(rrdy), .ReadValid(rvld),
    .ReadData(rdat), .ReadAck(rack), .ProgWrite(pw), .ProgAddr(paddr), .ProgData(pdat),
    .ProgLock(plock), .Locked(locked), .InitDone(idone), .ProgError(perr));

  instruction_rom_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(24), .DEFAULT_WORD(16'h0000)) dut_s (
    .clk(clk), .rst_n(rst_n), .ReadReq(s_rreq), .ReadAddr(s_raddr), .ReadReady(s_rrdy), .ReadValid(s_rvld),
    .ReadData(s_rdat), .ReadAck(s_rack), .ProgWrite(s_pw), .ProgAddr(s_paddr), .ProgData(s_pdat),
    .ProgLock(s_plock), .Locked(s_locked), .InitDone(s_idone), .ProgError(s_perr));

  typedef struct {
    bit          req;
    logic [9:0]  addr;
    bit          ack;
    bit          pw;
    logic [9:0]  paddr;
    logic [15:0] pdat;
    bit          lock;
    bit          exp_rdy;
    bit          exp_err;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] mdl [1024];
  logic [15:0] exp_q [$];
  vec_t        tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit req, logic [9:0] addr, bit ack, bit w, logic [9:0] wa,
                               logic [15:0] wd, bit lock, bit exp_rdy, bit exp_err);
    vec_t v;
    v.req = req; v.addr = addr; v.ack = ack; v.pw = w; v.paddr = wa; v.pdat = wd;
    v.lock = lock; v.exp_rdy = exp_rdy; v.exp_err = exp_err;
    return v;
  endfunction

  // One cycle on the big instance; called 1ns after a rising edge.
  task automatic step(input vec_t v);
    bit acc;
    rreq = v.req; raddr = v.addr; rack = v.ack; pw = v.pw; paddr = v.paddr; pdat = v.pdat; plock = v.lock;
    #1;
    chk("rd_ready", rrdy, v.exp_rdy);
    acc = v.req && rrdy;
    if (acc) exp_q.push_back(mdl[v.addr]);
    if (v.pw && !v.exp_err) mdl[v.paddr] = v.pdat;
    @(posedge clk); #1;
    chk("prog_error", perr, v.exp_err);
    if (acc) begin
      chk("rd_valid", rvld, 1);
      if (exp_q.size() > 0) chk("rd_data", rdat, exp_q.pop_front());
      else chk("rd_queue", 0, 1);
    end
    rreq = 0; rack = 0; pw = 0; plock = 0;
  endtask

  // One cycle on the small instance with ReadAck held high.
  task automatic sstep(input bit req, input logic [9:0] addr, input bit w, input logic [9:0] wa,
                       input logic [15:0] wd, input bit exp_err, input logic [15:0] exp_dat);
    s_rreq = req; s_raddr = addr; s_rack = 1; s_pw = w; s_paddr = wa; s_pdat = wd;
    @(posedge clk); #1;
    chk("s_prog_error", s_perr, exp_err);
    if (req) begin
      chk("s_rd_valid", s_rvld, 1);
      chk("s_rd_data", s_rdat, exp_dat);
    end
    s_rreq = 0; s_pw = 0;
  endtask

  initial begin
    int big_c, small_c, n;
    bit rdy_seen, s_rej;
    big_c = 0; small_c = 0; rdy_seen = 0; s_rej = 0;

    rst_n = 0;
    rreq = 0; raddr = '0; rack = 0; pw = 0; paddr = '0; pdat = '0; plock = 0;
    s_rreq = 0; s_raddr = '0; s_rack = 0; s_pw = 0; s_paddr = '0; s_pdat = '0; s_plock = 0;
    for (int i = 0; i < 1024; i++) mdl[i] = 16'h0000;

    tbl[0]  = mkv(1, 10'h005, 0, 0, 10'h000, 16'h0000, 0, 1, 0);
    tbl[1]  = mkv(0, 10'h000, 1, 1, 10'h000, 16'hD188, 0, 1, 0);
    tbl[2]  = mkv(0, 10'h000, 0, 1, 10'h001, 16'hC220, 0, 1, 0);
    tbl[3]  = mkv(1, 10'h001, 0, 0, 10'h000, 16'h0000, 0, 1, 0);
    tbl[4]  = mkv(1, 10'h003, 1, 1, 10'h003, 16'hA00F, 0, 1, 0);
    tbl[5]  = mkv(1, 10'h003, 1, 0, 10'h000, 16'h0000, 0, 1, 0);
    tbl[6]  = mkv(0, 10'h000, 1, 0, 10'h000, 16'h0000, 0, 1, 0);
    tbl[7]  = mkv(0, 10'h000, 0, 1, 10'h004, 16'h1111, 1, 1, 0);
    tbl[8]  = mkv(0, 10'h000, 0, 1, 10'h002, 16'hFFFF, 0, 1, 1);
    tbl[9]  = mkv(1, 10'h002, 0, 0, 10'h000, 16'h0000, 0, 1, 0);
    tbl[10] = mkv(1, 10'h004, 1, 0, 10'h000, 16'h0000, 0, 1, 0);
    tbl[11] = mkv(0, 10'h000, 1, 0, 10'h000, 16'h0000, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rvld, 0);
    chk("rst_data", rdat, 0);
    chk("rst_locked", locked, 0);
    chk("rst_error", perr, 0);
    chk("rst_initdone", idone, 0);
    chk("rst_ready", rrdy, 0);

    rst_n = 1;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk); #1;
      if (s_idone && small_c == 0) small_c = c;
      if (c == 2) begin
        s_pw = 1; s_paddr = 10'h000; s_pdat = 16'h1234;
      end
      if (c == 3) begin
        s_rej = s_perr; s_pw = 0;
      end
      if (idone) begin
        big_c = c;
        break;
      end
      if (rrdy) rdy_seen = 1;
    end
    chk("init_cycles", big_c, 1024);
    chk("s_init_cycles", small_c, 24);
    chk("init_ready_low", rdy_seen, 0);
    chk("init_write_reject", s_rej, 1);

    sstep(1, 10'h000, 0, 10'h000, 16'h0000, 0, 16'h0000);
    sstep(0, 10'h000, 1, 10'h017, 16'h5A5A, 0, 16'h0000);
    sstep(1, 10'h017, 0, 10'h000, 16'h0000, 0, 16'h5A5A);
    sstep(1, 10'h018, 0, 10'h000, 16'h0000, 0, 16'h0000);
    sstep(1, 10'h3FF, 0, 10'h000, 16'h0000, 0, 16'h0000);
    sstep(0, 10'h000, 1, 10'h018, 16'hFFFF, 1, 16'h0000);
    sstep(1, 10'h017, 0, 10'h000, 16'h0000, 0, 16'h5A5A);

    for (int i = 0; i <= 6; i++) step(tbl[i]);

    step(mkv(1, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 1, 0));
    repeat (3) begin
      step(mkv(1, 10'h001, 0, 0, 10'h000, 16'h0000, 0, 0, 0));
      chk("hold_data", rdat, 16'hD188);
      chk("hold_valid", rvld, 1);
    end
    step(mkv(1, 10'h001, 1, 0, 10'h000, 16'h0000, 0, 1, 0));
    step(mkv(0, 10'h000, 1, 0, 10'h000, 16'h0000, 0, 1, 0));
    chk("ack_clears_valid", rvld, 0);
    chk("ack_holds_data", rdat, 16'hC220);

    for (int i = 7; i <= 11; i++) step(tbl[i]);
    chk("locked_sticky", locked, 1);

    step(mkv(1, 10'h001, 0, 0, 10'h000, 16'h0000, 0, 1, 0));
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", rvld, 0);
    chk("arst_locked", locked, 0);
    chk("arst_initdone", idone, 0);
    chk("arst_ready", rrdy, 0);
    chk("arst_data", rdat, 0);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) mdl[i] = 16'h0000;

    @(posedge clk); #1;
    rst_n = 1;
    plock = 1;
    @(posedge clk); #1;
    plock = 0;
    n = 1;
    chk("init_lock", locked, 1);
    while (!idone && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("refill_cycles", n, 1024);
    step(mkv(1, 10'h001, 0, 0, 10'h000, 16'h0000, 0, 1, 0));
    chk("refill_data", rdat, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
